// File: rtl/sd_spi_card_model_if.sv
// SPI-mode SD card pin bundle plus card-side decode status for scoreboarding.
// The master modport is the host/bench side, the slave modport is the card model.
interface sd_spi_card_model_if;
  logic        SD_CS;
  logic        SD_IN;
  logic        SD_OUT;
  logic        init_done;
  logic        cmd_valid;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic        wr_valid;
  logic [7:0]  wr_byte;

  modport master (
    output SD_CS, SD_IN,
    input  SD_OUT, init_done, cmd_valid, cmd_idx, cmd_arg, wr_valid, wr_byte
  );

  modport slave (
    input  SD_CS, SD_IN,
    output SD_OUT, init_done, cmd_valid, cmd_idx, cmd_arg, wr_valid, wr_byte
  );
endinterface

// File: rtl/sd_spi_card_model.sv
// SPI-mode SD card responder: decodes 48-bit frames from SD_IN and answers with R1/R7,
// read blocks and write data-response/busy. SD_IN is sampled on rise, SD_OUT driven on fall.
module sd_spi_card_model #(
  parameter int unsigned NCR          = 1,
  parameter int unsigned BLOCK_LEN    = 512,
  parameter int unsigned RD_GAP       = 1,
  parameter int unsigned ACMD41_TRIES = 2,
  parameter int unsigned BUSY_CYCLES  = 16
) (
  input  logic                  SD_CLK,
  input  logic                  rst,
  sd_spi_card_model_if.slave    bus
);
  typedef enum logic [3:0] {
    S_HUNT, S_RX_CMD, S_NCR_WAIT, S_RESP,
    S_RD_GAP, S_RD_TOKEN, S_RD_DATA, S_RD_CRC,
    S_WR_TOKEN, S_WR_DATA, S_WR_CRC, S_WR_DRESP, S_WR_BUSY
  } state_t;

  localparam logic [7:0] DATA_TOKEN = 8'hFE;

  state_t      r_state, w_state_nx;
  logic [12:0] r_byte, w_byte_nx;
  logic [2:0]  r_bit, w_bit_nx;
  logic [46:0] r_rx, w_rx_nx;
  logic [39:0] r_tx, w_tx_nx;
  logic [2:0]  r_resp_last, w_resp_last_nx;
  logic [7:0]  r_sh;
  logic        r_seen0, w_seen0_nx;
  logic        r_app, w_app_nx;
  logic        r_init, w_init_nx;
  logic [15:0] r_acmd, w_acmd_nx;
  logic        r_rd, w_rd_nx;
  logic        r_wr, w_wr_nx;
  logic        r_cmd_valid, w_cmd_valid_nx;
  logic [5:0]  r_cmd_idx, w_cmd_idx_nx;
  logic [31:0] r_cmd_arg, w_cmd_arg_nx;
  logic        r_wr_valid, w_wr_valid_nx;
  logic [7:0]  r_wr_byte, w_wr_byte_nx;
  logic        r_out, w_tx_bit;

  logic [47:0] w_frame;
  logic [31:0] w_arg;
  logic [5:0]  w_idx;
  logic [7:0]  w_in_byte, w_rd_byte, w_illegal;
  logic        w_unused;

  assign w_frame   = {r_rx, bus.SD_IN};
  assign w_idx     = w_frame[45:40];
  assign w_arg     = w_frame[39:8];
  assign w_in_byte = {r_sh[6:0], bus.SD_IN};
  assign w_illegal = r_init ? 8'h04 : 8'h05;
  assign w_unused  = ^{w_frame[47:46], w_frame[7:1]};

  always_comb begin
    w_state_nx     = r_state;
    w_byte_nx      = r_byte;
    w_bit_nx       = r_bit + 3'd1;
    w_rx_nx        = r_rx;
    w_tx_nx        = r_tx;
    w_resp_last_nx = r_resp_last;
    w_seen0_nx     = 1'b0;
    w_app_nx       = r_app;
    w_init_nx      = r_init;
    w_acmd_nx      = r_acmd;
    w_rd_nx        = r_rd;
    w_wr_nx        = r_wr;
    w_cmd_valid_nx = 1'b0;
    w_cmd_idx_nx   = r_cmd_idx;
    w_cmd_arg_nx   = r_cmd_arg;
    w_wr_valid_nx  = 1'b0;
    w_wr_byte_nx   = r_wr_byte;
    if (bus.SD_CS) begin
      w_state_nx = S_HUNT;
      w_byte_nx  = '0;
      w_bit_nx   = '0;
    end else begin
      unique case (r_state)
        S_HUNT: begin
          w_bit_nx   = '0;
          w_seen0_nx = ~bus.SD_IN;
          if (r_seen0 && bus.SD_IN) begin
            w_state_nx = S_RX_CMD;
            w_rx_nx    = 47'b01;
            w_byte_nx  = '0;
          end
        end
        S_RX_CMD: begin
          w_bit_nx  = '0;
          w_rx_nx   = w_frame[46:0];
          w_byte_nx = r_byte + 13'd1;
          if (r_byte == 13'd45) begin
            w_byte_nx = '0;
            if (!bus.SD_IN) begin
              w_state_nx = S_HUNT;
            end else begin
              w_state_nx     = S_NCR_WAIT;
              w_cmd_valid_nx = 1'b1;
              w_cmd_idx_nx   = w_idx;
              w_cmd_arg_nx   = w_arg;
              w_resp_last_nx = 3'd0;
              w_app_nx       = 1'b0;
              w_rd_nx        = 1'b0;
              w_wr_nx        = 1'b0;
              w_tx_nx        = {w_illegal, 32'h0};
              case (w_idx)
                6'd0: begin
                  w_tx_nx   = {8'h01, 32'h0};
                  w_init_nx = 1'b0;
                  w_acmd_nx = '0;
                end
                6'd8: begin
                  w_tx_nx        = {8'h01, 8'h00, 8'h00, 4'h0, w_arg[11:8], w_arg[7:0]};
                  w_resp_last_nx = 3'd4;
                end
                6'd55: begin
                  w_tx_nx  = {(r_init ? 8'h00 : 8'h01), 32'h0};
                  w_app_nx = 1'b1;
                end
                6'd41: begin
                  if (r_app) begin
                    if (r_acmd < 16'(ACMD41_TRIES)) begin
                      w_tx_nx   = {8'h01, 32'h0};
                      w_acmd_nx = r_acmd + 16'd1;
                    end else begin
                      w_tx_nx   = {8'h00, 32'h0};
                      w_init_nx = 1'b1;
                    end
                  end
                end
                6'd17: if (r_init) begin
                  w_tx_nx = {8'h00, 32'h0};
                  w_rd_nx = 1'b1;
                end
                6'd24: if (r_init) begin
                  w_tx_nx = {8'h00, 32'h0};
                  w_wr_nx = 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        S_NCR_WAIT: if (r_bit == 3'd7) begin
          w_byte_nx = r_byte + 13'd1;
          if (r_byte == 13'(NCR - 1)) begin
            w_state_nx = S_RESP;
            w_byte_nx  = '0;
          end
        end
        S_RESP: begin
          w_tx_nx = {r_tx[38:0], 1'b1};
          if (r_bit == 3'd7) begin
            w_byte_nx = r_byte + 13'd1;
            if (r_byte == 13'(r_resp_last)) begin
              w_byte_nx = '0;
              if (r_rd)      w_state_nx = (RD_GAP == 0) ? S_RD_TOKEN : S_RD_GAP;
              else if (r_wr) w_state_nx = S_WR_TOKEN;
              else           w_state_nx = S_HUNT;
            end
          end
        end
        S_RD_GAP: if (r_bit == 3'd7) begin
          w_byte_nx = r_byte + 13'd1;
          if (r_byte == 13'(RD_GAP - 1)) begin
            w_state_nx = S_RD_TOKEN;
            w_byte_nx  = '0;
          end
        end
        S_RD_TOKEN: if (r_bit == 3'd7) w_state_nx = S_RD_DATA;
        S_RD_DATA: if (r_bit == 3'd7) begin
          w_byte_nx = r_byte + 13'd1;
          if (r_byte == 13'(BLOCK_LEN - 1)) begin
            w_state_nx = S_RD_CRC;
            w_byte_nx  = '0;
          end
        end
        S_RD_CRC: if (r_bit == 3'd7) begin
          w_byte_nx = r_byte + 13'd1;
          if (r_byte == 13'd1) begin
            w_state_nx = S_HUNT;
            w_byte_nx  = '0;
          end
        end
        // Token hunt stays aligned to the byte grid set by the end of R1.
        S_WR_TOKEN: if (r_bit == 3'd7 && w_in_byte == DATA_TOKEN) w_state_nx = S_WR_DATA;
        S_WR_DATA: if (r_bit == 3'd7) begin
          w_wr_valid_nx = 1'b1;
          w_wr_byte_nx  = w_in_byte;
          w_byte_nx     = r_byte + 13'd1;
          if (r_byte == 13'(BLOCK_LEN - 1)) begin
            w_state_nx = S_WR_CRC;
            w_byte_nx  = '0;
          end
        end
        S_WR_CRC: if (r_bit == 3'd7) begin
          w_byte_nx = r_byte + 13'd1;
          if (r_byte == 13'd1) begin
            w_state_nx = S_WR_DRESP;
            w_byte_nx  = '0;
            w_tx_nx    = {8'h05, 32'h0};
          end
        end
        S_WR_DRESP: begin
          w_tx_nx = {r_tx[38:0], 1'b1};
          if (r_bit == 3'd7) w_state_nx = S_WR_BUSY;
        end
        S_WR_BUSY: begin
          w_bit_nx  = '0;
          w_byte_nx = r_byte + 13'd1;
          if (r_byte == 13'(BUSY_CYCLES - 1)) begin
            w_state_nx = S_HUNT;
            w_byte_nx  = '0;
          end
        end
        default: w_state_nx = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge SD_CLK or posedge rst) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_byte      <= '0;
      r_bit       <= '0;
      r_rx        <= '0;
      r_tx        <= '1;
      r_resp_last <= '0;
      r_sh        <= '1;
      r_seen0     <= 1'b0;
      r_app       <= 1'b0;
      r_init      <= 1'b0;
      r_acmd      <= '0;
      r_rd        <= 1'b0;
      r_wr        <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_idx   <= '0;
      r_cmd_arg   <= '0;
      r_wr_valid  <= 1'b0;
      r_wr_byte   <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_byte      <= w_byte_nx;
      r_bit       <= w_bit_nx;
      r_rx        <= w_rx_nx;
      r_tx        <= w_tx_nx;
      r_resp_last <= w_resp_last_nx;
      r_sh        <= w_in_byte;
      r_seen0     <= w_seen0_nx;
      r_app       <= w_app_nx;
      r_init      <= w_init_nx;
      r_acmd      <= w_acmd_nx;
      r_rd        <= w_rd_nx;
      r_wr        <= w_wr_nx;
      r_cmd_valid <= w_cmd_valid_nx;
      r_cmd_idx   <= w_cmd_idx_nx;
      r_cmd_arg   <= w_cmd_arg_nx;
      r_wr_valid  <= w_wr_valid_nx;
      r_wr_byte   <= w_wr_byte_nx;
    end
  end

  // State after a rising edge selects the bit launched on the following falling edge.
  always_comb begin
    w_rd_byte = r_cmd_arg[7:0] + r_byte[7:0];
    w_tx_bit  = 1'b1;
    case (r_state)
      S_RESP, S_WR_DRESP: w_tx_bit = r_tx[39];
      S_RD_TOKEN:         w_tx_bit = DATA_TOKEN[~r_bit];
      S_RD_DATA:          w_tx_bit = w_rd_byte[~r_bit];
      S_WR_BUSY:          w_tx_bit = 1'b0;
      default:            w_tx_bit = 1'b1;
    endcase
  end

  always_ff @(negedge SD_CLK or posedge rst) begin
    if (rst) r_out <= 1'b1;
    else     r_out <= w_tx_bit;
  end

  assign bus.SD_OUT    = r_out;
  assign bus.init_done = r_init;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_idx   = r_cmd_idx;
  assign bus.cmd_arg   = r_cmd_arg;
  assign bus.wr_valid  = r_wr_valid;
  assign bus.wr_byte   = r_wr_byte;
endmodule

// File: tb/tb_sd_spi_card_model.sv
// Directed bench for sd_spi_card_model: host side drives SD_IN on falling edges and
// captures SD_OUT just after rising edges, byte by byte.
module tb_sd_spi_card_model;
  logic SD_CLK;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_cmdv = 0;
  logic [7:0] wr_log [$];
  logic [7:0] rx;

  sd_spi_card_model_if bus ();

  sd_spi_card_model #(
    .NCR(1), .BLOCK_LEN(4), .RD_GAP(1), .ACMD41_TRIES(2), .BUSY_CYCLES(16)
  ) dut (
    .SD_CLK(SD_CLK),
    .rst   (rst),
    .bus   (bus)
  );

  initial begin
    SD_CLK = 1'b0;
    forever #5 SD_CLK = ~SD_CLK;
  end

  always @(negedge SD_CLK) begin
    if (bus.cmd_valid === 1'b1) n_cmdv++;
    if (bus.wr_valid === 1'b1) wr_log.push_back(bus.wr_byte);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] r);
    logic [7:0] t;
    t = tx;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      @(negedge SD_CLK);
      #1 bus.SD_IN = t[i];
      @(posedge SD_CLK);
      #1 r = {r[6:0], bus.SD_OUT};
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [47:0] f;
    logic [7:0]  d;
    f = {2'b01, idx, arg, crc};
    for (int b = 5; b >= 0; b--) xfer(f[b*8 +: 8], d);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] r;
    xfer(8'hFF, r);
    chk(tag, {56'h0, r}, {56'h0, exp});
  endtask

  initial begin
    int cv0;
    rst        = 1'b0;
    bus.SD_CS  = 1'b1;
    bus.SD_IN  = 1'b1;
    #2 rst = 1'b1;
    #20;
    chk("rst_sd_out",    {63'h0, bus.SD_OUT},    64'h1);
    chk("rst_init_done", {63'h0, bus.init_done}, 64'h0);
    chk("rst_cmd_valid", {63'h0, bus.cmd_valid}, 64'h0);
    chk("rst_wr_valid",  {63'h0, bus.wr_valid},  64'h0);
    chk("rst_cmd_idx",   {58'h0, bus.cmd_idx},   64'h0);
    chk("rst_cmd_arg",   {32'h0, bus.cmd_arg},   64'h0);
    @(negedge SD_CLK);
    rst = 1'b0;
    bus.SD_CS = 1'b0;
    xfer(8'hFF, rx);
    xfer(8'hFF, rx);

    // CMD0
    cv0 = n_cmdv;
    send_cmd(6'd0, 32'h0, 8'h95);
    chk("cmd0_valid", {63'h0, bus.cmd_valid}, 64'h1);
    chk("cmd0_idx",   {58'h0, bus.cmd_idx},   64'h0);
    expect_byte("cmd0_ncr", 8'hFF);
    expect_byte("cmd0_r1",  8'h01);
    chk("cmd0_pulses", 64'(n_cmdv - cv0), 64'd1);
    expect_byte("cmd0_idle", 8'hFF);

    // CMD8 R7
    send_cmd(6'd8, 32'h0000_01AA, 8'h87);
    chk("cmd8_idx", {58'h0, bus.cmd_idx}, 64'd8);
    chk("cmd8_arg", {32'h0, bus.cmd_arg}, 64'h1AA);
    expect_byte("cmd8_ncr", 8'hFF);
    expect_byte("cmd8_b0", 8'h01);
    expect_byte("cmd8_b1", 8'h00);
    expect_byte("cmd8_b2", 8'h00);
    expect_byte("cmd8_b3", 8'h01);
    expect_byte("cmd8_b4", 8'hAA);

    // CMD55 + ACMD41 x3
    send_cmd(6'd55, 32'h0, 8'h65); expect_byte("c55a_ncr", 8'hFF); expect_byte("c55a_r1", 8'h01);
    send_cmd(6'd41, 32'h4000_0000, 8'h77); expect_byte("a41a_ncr", 8'hFF); expect_byte("a41a_r1", 8'h01);
    send_cmd(6'd55, 32'h0, 8'h65); expect_byte("c55b_r1n", 8'hFF); expect_byte("c55b_r1", 8'h01);
    send_cmd(6'd41, 32'h4000_0000, 8'h77); expect_byte("a41b_ncr", 8'hFF); expect_byte("a41b_r1", 8'h01);
    chk("init_low_b", {63'h0, bus.init_done}, 64'h0);
    send_cmd(6'd55, 32'h0, 8'h65); expect_byte("c55c_ncr", 8'hFF); expect_byte("c55c_r1", 8'h01);
    send_cmd(6'd41, 32'h4000_0000, 8'h77); expect_byte("a41c_ncr", 8'hFF); expect_byte("a41c_r1", 8'h00);
    chk("init_high", {63'h0, bus.init_done}, 64'h1);
    send_cmd(6'd55, 32'h0, 8'h65); expect_byte("c55d_ncr", 8'hFF); expect_byte("c55d_r1", 8'h00);

    // unknown command after init
    send_cmd(6'd5, 32'h0, 8'h01); expect_byte("cmd5i_ncr", 8'hFF); expect_byte("cmd5i_r1", 8'h04);

    // CMD17 full block
    send_cmd(6'd17, 32'h0000_0010, 8'h01);
    expect_byte("rd_ncr", 8'hFF);
    expect_byte("rd_r1", 8'h00);
    expect_byte("rd_gap", 8'hFF);
    expect_byte("rd_tok", 8'hFE);
    expect_byte("rd_d0", 8'h10);
    expect_byte("rd_d1", 8'h11);
    expect_byte("rd_d2", 8'h12);
    expect_byte("rd_d3", 8'h13);
    expect_byte("rd_crc0", 8'hFF);
    expect_byte("rd_crc1", 8'hFF);
    expect_byte("rd_idle", 8'hFF);

    // CMD24 write
    send_cmd(6'd24, 32'h0000_0200, 8'h01);
    expect_byte("wr_ncr", 8'hFF);
    expect_byte("wr_r1", 8'h00);
    xfer(8'hFF, rx); chk("wr_pre",  {56'h0, rx}, 64'hFF);
    xfer(8'hFE, rx); chk("wr_tok",  {56'h0, rx}, 64'hFF);
    xfer(8'hA1, rx);
    xfer(8'hB2, rx);
    xfer(8'hC3, rx);
    xfer(8'hD4, rx); chk("wr_d3", {56'h0, rx}, 64'hFF);
    chk("wr_byte_last", {56'h0, bus.wr_byte}, 64'hD4);
    xfer(8'h00, rx);
    xfer(8'h00, rx);
    chk("wr_count", 64'(wr_log.size()), 64'd4);
    if (wr_log.size() == 4) begin
      chk("wr_log0", {56'h0, wr_log[0]}, 64'hA1);
      chk("wr_log1", {56'h0, wr_log[1]}, 64'hB2);
      chk("wr_log2", {56'h0, wr_log[2]}, 64'hC3);
      chk("wr_log3", {56'h0, wr_log[3]}, 64'hD4);
    end
    expect_byte("wr_dresp", 8'h05);
    expect_byte("wr_busy0", 8'h00);
    expect_byte("wr_busy1", 8'h00);
    expect_byte("wr_idle",  8'hFF);

    // CS raised mid-read
    send_cmd(6'd17, 32'h0000_0010, 8'h01);
    expect_byte("ab_ncr", 8'hFF);
    expect_byte("ab_r1",  8'h00);
    expect_byte("ab_gap", 8'hFF);
    expect_byte("ab_tok", 8'hFE);
    expect_byte("ab_d0",  8'h10);
    expect_byte("ab_d1",  8'h11);
    bus.SD_CS = 1'b1;
    @(posedge SD_CLK);
    @(negedge SD_CLK);
    #1 chk("ab_sd_out", {63'h0, bus.SD_OUT}, 64'h1);
    xfer(8'hFF, rx); chk("ab_cs_high", {56'h0, rx}, 64'hFF);
    bus.SD_CS = 1'b0;
    xfer(8'hFF, rx);

    send_cmd(6'd0, 32'h0, 8'h95);
    expect_byte("c0b_ncr", 8'hFF);
    expect_byte("c0b_r1", 8'h01);
    chk("c0b_init", {63'h0, bus.init_done}, 64'h0);

    // CMD17 before init: no data phase
    send_cmd(6'd17, 32'h0, 8'h01);
    expect_byte("rdni_ncr", 8'hFF);
    expect_byte("rdni_r1",  8'h05);
    expect_byte("rdni_x0",  8'hFF);
    expect_byte("rdni_x1",  8'hFF);

    send_cmd(6'd5, 32'h0, 8'h01);
    expect_byte("cmd5_ncr", 8'hFF);
    expect_byte("cmd5_r1",  8'h05);
    chk("cmd5_idx", {58'h0, bus.cmd_idx}, 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
